// File: rtl/cv32e40s_write_buffer_fifo_if.sv
// Shared request/response types and the LSU-to-OBI write buffer handshake bundle.
// The master side issues requests and bus ready; the slave side is the buffer.
package cv32e40s_pkg;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        integrity;
  } pma_cfg_t;

  parameter pma_cfg_t PMA_R_DEFAULT = '{main: 1'b1, default: '0};

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  atop;
    logic [3:0]  be;
    logic [2:0]  prot;
    logic [1:0]  memtype;
    logic        we;
    logic [31:0] wdata;
    logic        dbg;
  } obi_data_req_t;

  parameter obi_data_req_t OBI_DATA_REQ_RESET = '{we: 1'b1, default: '0};

endpackage

interface cv32e40s_write_buffer_fifo_if #(
  parameter int DEPTH = 2
);
  import cv32e40s_pkg::*;

  logic                         valid_i;
  obi_data_req_t                trans_i;
  logic                         ready_i;
  logic                         valid_o;
  obi_data_req_t                trans_o;
  logic                         ready_o;
  logic                         empty_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output valid_i, trans_i, ready_i,
    input  valid_o, trans_o, ready_o, empty_o, count_o
  );

  modport slave (
    input  valid_i, trans_i, ready_i,
    output valid_o, trans_o, ready_o, empty_o, count_o
  );

endinterface

// File: rtl/cv32e40s_write_buffer_fifo.sv
// In-order write buffer: bufferable stores are queued, everything else bypasses once drained.
// Zero-latency bypass when empty; entries appear on trans_o the cycle after push.
module cv32e40s_write_buffer_fifo
  import cv32e40s_pkg::*;
#(
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
  parameter int       DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cv32e40s_write_buffer_fifo_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [PTR_W-1:0] ptr_t;

  obi_data_req_t      mem_q [DEPTH];
  ptr_t               rd_ptr_q;
  ptr_t               wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic bs;
  logic empty;
  logic full;
  logic push;
  logic pop;

  // PMA configuration only shapes the package types; there is no local decode.
  logic unused_pma;
  assign unused_pma = ^{$bits(PMA_CFG), PMA_NUM_REGIONS};

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign bs    = bus.trans_i.memtype[0] && bus.trans_i.we;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    bus.valid_o = bus.valid_i;
    bus.trans_o = bus.trans_i;
    bus.ready_o = bs || bus.ready_i;
    push        = 1'b0;
    pop         = 1'b0;
    if (empty) begin
      push = bus.valid_i && bs && !bus.ready_i;
    end else begin
      // Non-bufferable traffic must wait until every older store is on the bus.
      bus.valid_o = 1'b1;
      bus.trans_o = mem_q[rd_ptr_q];
      pop         = bus.ready_i;
      bus.ready_o = bs && (!full || bus.ready_i);
      push        = bus.valid_i && bus.ready_o;
    end
  end

  assign bus.empty_o = empty;
  assign bus.count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OBI_DATA_REQ_RESET;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.trans_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_cv32e40s_write_buffer_fifo.sv
// Directed vector bench for the write buffer with DEPTH=3, plus wrap and async-reset sequences.
module tb_cv32e40s_write_buffer_fifo;
  import cv32e40s_pkg::*;

  localparam int DEPTH = 3;
  localparam int K_BS = 0;   // bufferable store
  localparam int K_LD = 1;   // load
  localparam int K_NB = 2;   // non-bufferable store

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cv32e40s_write_buffer_fifo_if #(.DEPTH(DEPTH)) bus ();

  cv32e40s_write_buffer_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    int          kind;
    logic [31:0] addr;
    logic        rdy;
    logic        evo;
    logic [31:0] eao;
    logic        ero;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, int kind, logic [31:0] addr, logic rdy,
                              logic evo, logic [31:0] eao, logic ero, int ecnt);
    vec_t r;
    r.v = v; r.kind = kind; r.addr = addr; r.rdy = rdy;
    r.evo = evo; r.eao = eao; r.ero = ero; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic drive(input logic v, input int kind, input logic [31:0] addr, input logic rdy);
    obi_data_req_t t;
    t         = '0;
    t.addr    = addr;
    t.wdata   = ~addr;
    t.be      = 4'hF;
    t.we      = (kind != K_LD);
    t.memtype = {1'b0, (kind != K_NB)};
    bus.valid_i = v;
    bus.trans_i = t;
    bus.ready_i = rdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] out_q[$];
  int          next_in;

  initial begin
    drive(1'b0, K_LD, 32'h0, 1'b0);
    #1;
    chk("reset empty_o", 32'(bus.empty_o), 32'd1);
    chk("reset count_o", 32'(bus.count_o), 32'd0);
    chk("reset valid_o", 32'(bus.valid_o), 32'd0);
    chk("reset ready_o load", 32'(bus.ready_o), 32'd0);
    drive(1'b1, K_BS, 32'h44, 1'b0);
    #1;
    chk("reset bypass valid_o", 32'(bus.valid_o), 32'd1);
    chk("reset bypass addr", bus.trans_o.addr, 32'h44);
    chk("reset bypass ready_o", 32'(bus.ready_o), 32'd1);
    drive(1'b0, K_LD, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single bs held by a stalled bus.
    vecs.push_back(mk(1, K_BS, 32'h100, 0, 1, 32'h100, 1, 0));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 1, 32'h100, 0, 1));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 1, 32'h100, 0, 1));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 1, 32'h100, 0, 1));
    vecs.push_back(mk(0, K_LD, 32'h0,   1, 1, 32'h100, 0, 1));
    // Non-bufferable store while empty waits for the bus, never stored.
    vecs.push_back(mk(1, K_NB, 32'h200, 0, 1, 32'h200, 0, 0));
    vecs.push_back(mk(1, K_NB, 32'h200, 0, 1, 32'h200, 0, 0));
    vecs.push_back(mk(1, K_NB, 32'h200, 1, 1, 32'h200, 1, 0));
    // Fill to DEPTH, fourth blocked until a pop frees a slot in the same cycle.
    vecs.push_back(mk(1, K_BS, 32'h10,  0, 1, 32'h10,  1, 0));
    vecs.push_back(mk(1, K_BS, 32'h14,  0, 1, 32'h10,  1, 1));
    vecs.push_back(mk(1, K_BS, 32'h18,  0, 1, 32'h10,  1, 2));
    vecs.push_back(mk(1, K_BS, 32'h1C,  0, 1, 32'h10,  0, 3));
    vecs.push_back(mk(1, K_BS, 32'h1C,  1, 1, 32'h10,  1, 3));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 1, 32'h14,  0, 3));
    // Load waits for the drain, then bypasses.
    vecs.push_back(mk(1, K_LD, 32'h300, 1, 1, 32'h14,  0, 3));
    vecs.push_back(mk(1, K_LD, 32'h300, 1, 1, 32'h18,  0, 2));
    vecs.push_back(mk(1, K_LD, 32'h300, 1, 1, 32'h1C,  0, 1));
    vecs.push_back(mk(1, K_LD, 32'h300, 1, 1, 32'h300, 1, 0));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 0, 32'h0,   0, 0));
    // bs with ready bus passes straight through.
    vecs.push_back(mk(1, K_BS, 32'h400, 1, 1, 32'h400, 1, 0));
    vecs.push_back(mk(0, K_LD, 32'h0,   0, 0, 32'h0,   0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].v, vecs[i].kind, vecs[i].addr, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d valid_o", i), 32'(bus.valid_o), 32'(vecs[i].evo));
      chk($sformatf("v%0d ready_o", i), 32'(bus.ready_o), 32'(vecs[i].ero));
      chk($sformatf("v%0d count_o", i), 32'(bus.count_o), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d empty_o", i), 32'(bus.empty_o), 32'(vecs[i].ecnt == 0));
      if (vecs[i].evo) begin
        chk($sformatf("v%0d addr", i), bus.trans_o.addr, vecs[i].eao);
        chk($sformatf("v%0d wdata", i), bus.trans_o.wdata, ~vecs[i].eao);
      end
    end

    // Seven stores through a 3-deep buffer under a stall pattern; order must survive wrap.
    next_in = 0;
    for (int cyc = 0; cyc < 60 && out_q.size() < 7; cyc++) begin
      @(posedge clk);
      #1;
      drive(next_in < 7, next_in < 7 ? K_BS : K_LD, 32'h1000 + 32'(next_in) * 4,
            (cyc % 3) != 0 && cyc > 3);
      @(negedge clk);
      if (bus.valid_i && bus.ready_o) next_in++;
      if (bus.valid_o && bus.ready_i) out_q.push_back(bus.trans_o.addr);
    end
    chk("wrap out count", 32'(out_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < out_q.size(); i++) begin
      chk($sformatf("wrap order %0d", i), out_q[i], 32'h1000 + 32'(i) * 4);
    end

    // Async reset with two stores buffered.
    @(posedge clk); #1; drive(1'b1, K_BS, 32'h600, 1'b0);
    @(posedge clk); #1; drive(1'b1, K_BS, 32'h604, 1'b0);
    @(posedge clk); #1; drive(1'b0, K_LD, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre-reset count_o", 32'(bus.count_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset empty_o", 32'(bus.empty_o), 32'd1);
    chk("async reset count_o", 32'(bus.count_o), 32'd0);
    chk("async reset valid_o", 32'(bus.valid_o), 32'd0);
    drive(1'b1, K_BS, 32'h500, 1'b0);
    #1;
    chk("reset bypass valid_o", 32'(bus.valid_o), 32'd1);
    chk("reset bypass trans_o", bus.trans_o.addr, 32'h500);
    drive(1'b0, K_LD, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-reset valid_o", 32'(bus.valid_o), 32'd0);
    chk("post-reset count_o", 32'(bus.count_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40s_write_buffer_fifo.md
# cv32e40s_write_buffer_fifo

Parametrised multi-entry write buffer between the load-store unit and the OBI data interface. Bufferable stores are absorbed into an in-order FIFO of DEPTH entries, so the core retires them without waiting for the bus. All other transfers pass straight through, but only once the FIFO has fully drained, so bus order equals program order. With DEPTH=1 it behaves as the single-word buffer, except that loads are never buffered.

## Interface
Parameters:
- PMA_NUM_REGIONS, 0, number of PMA regions (passed through for the package types; no local decode).
- PMA_CFG, '{default:PMA_R_DEFAULT}, PMA region configuration array.
- DEPTH, 2, number of FIFO entries; legal range 1..8; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- valid_i  input  1  upstream request valid.
- trans_i  input  obi_data_req_t  upstream request; trans_i.memtype[0] marks it bufferable.
- ready_i  input  1  downstream (OBI) ready.
- valid_o  output  1  downstream request valid.
- trans_o  output  obi_data_req_t  downstream request.
- ready_o  output  1  upstream ready.
- empty_o  output  1  FIFO holds no entries.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- A request is a buffer candidate (bs) when it is a bufferable store: trans_i.memtype[0] && trans_i.we.
- Storage: DEPTH entries of obi_data_req_t, a read pointer, a write pointer and an occupancy count.
  - Each pointer wraps from DEPTH-1 to 0 on increment; this is explicit, not modulo-2^n.
- Empty (count==0), bypass mode:
  - valid_o = valid_i; trans_o = trans_i.
  - ready_o = bs || ready_i.
  - push = valid_i && bs && !ready_i. The entry is written, the write pointer increments, and count becomes 1.
  - If ready_i=1, the request passes through and nothing is stored.
- Non-empty (count>0):
  - valid_o = 1; trans_o = entry[read pointer].
  - pop = ready_i. The read pointer increments and count decrements.
  - ready_o = bs && (count<DEPTH || ready_i).
  - push = valid_i && ready_o. The entry is written at the write pointer, which then increments.
  - A non-bs request (load, or non-bufferable store) sees ready_o=0 until count returns to 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full.
- Count update each cycle: count_next = count + push - pop. It never exceeds DEPTH and never goes below 0.
- empty_o = (count==0); count_o = count.
- Entries are only written on push; a stale entry is never presented.
- Reset values:
  - count=0, both pointers=0.
  - All entries = obi_data_req_t'{we:1, default:0}.
  - Hence empty_o=1 and count_o=0.
  - valid_o, trans_o and ready_o follow the bypass equations above, all combinational from the inputs.
- Reset mid-operation: buffered stores are discarded and the block returns to empty and bypass immediately (asynchronous).

## Timing
- Bypass latency: 0 cycles. valid_i, trans_i and ready_i reach the outputs combinationally when empty.
- A request pushed in cycle N is presented on trans_o from cycle N+1, held stable with valid_o=1 until ready_i.
  - This keeps the OBI rule that valid is never retracted without a handshake.
- ready_i→ready_o is combinational in all states. No combinational path exists from trans_i to trans_o when non-empty.
- Throughput: one push and one pop per cycle sustained. A full FIFO accepts a new bs only in a cycle with ready_i=1.
- Drain time before a non-bs request is accepted equals count cycles, given ready_i held high.

## Test plan
- Reset, then a bs with ready_i=0 for 3 cycles → cycle 0: ready_o=1 and push. Cycles 1-3: valid_o=1, trans_o equals that request, count_o=1.
- DEPTH=3; 4 bs at addresses 0x10,0x14,0x18,0x1C with ready_i=0 → first three accepted (count_o=3). Fourth sees ready_o=0. Raise ready_i for 1 cycle → 0x10 pops and 0x1C pushes in the same cycle, and count_o stays 3.
- Buffer holds 2 entries and a load is presented with ready_i=1 → ready_o=0 for 2 cycles. trans_o shows the two stores in order. Cycle 3: empty_o=1, the load bypasses, ready_o=1.
- Non-bufferable store while empty with ready_i=0 → ready_o=0, valid_o=1, trans_o=trans_i, count_o stays 0.
- DEPTH=3 wrap: 7 pushes/pops interleaved → output order exactly matches input order across pointer wrap 2→0.
- Assert rst_n low with count_o=2 mid-stream → empty_o=1 and count_o=0 immediately. valid_o follows valid_i, and no buffered store appears afterwards.
